combo_checker: RTL and testbench
================================

COMBO_CHECKER -- requirements
Module: combo_checker

Interface
REQ-001 Parameters: CODE0 default 5, CODE1 default 20, CODE2 default 12 (reset-time combination, each 0..30); MAX_FAILS default 3 (wrong entries before alarm); LOCKOUT default 16 (alarm duration in cycles); OPEN_TIME default 64 (cycles before auto-relock).
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  synchronous, active-low reset.
REQ-004 dial  input  5  current dial number from the dial counter; legal values 0..30.
REQ-005 sel  input  2  dial direction: 00 = down, 01 = up, 11 = hold, 10 = illegal.
REQ-006 enter  input  1  level input; a rising edge commits the current dial value.
REQ-007 relock  input  1  level input; relocks from OPEN or PROG.
REQ-008 prog  input  1  level input; requests reprogramming while OPEN.
REQ-009 unlocked  output  1  high while in OPEN.
REQ-010 alarm  output  1  high while in ALARM.
REQ-011 stage  output  2  number of correct entries accepted in the current attempt (0..2); also the slot index while in PROG.
REQ-012 fail_cnt  output  2  consecutive wrong entries, saturating at MAX_FAILS.
REQ-013 cnt_load  output  1  one-cycle pulse that loads the dial counter.
REQ-014 cnt_value  output  5  value for the dial counter to load; always 0.

Function
REQ-015 An enter edge is enter=1 in cycle N with registered enter=0 from cycle N-1; a held-high enter produces exactly one edge.
REQ-016 States: IDLE, GOT1, GOT2, OPEN, PROG, ALARM; all outputs registered and decoded from state/counters.
REQ-017 IDLE: on an edge with dial==code[0] and sel==01, go to GOT1 with stage=1.
REQ-018 GOT1: on an edge with dial==code[1] and sel==00, go to GOT2 with stage=2.
REQ-019 GOT2: on an edge with dial==code[2] and sel==01, go to OPEN; clear fail_cnt and stage.
REQ-020 Wrong entry: in IDLE/GOT1/GOT2, any edge with a dial mismatch, wrong direction, sel in {10,11}, or dial>30 does all of the following:
- go to IDLE with stage=0;
- increment fail_cnt;
- pulse cnt_load for one cycle with cnt_value=0.
REQ-021 If a wrong entry makes fail_cnt reach MAX_FAILS, go to ALARM instead of IDLE and load the lockout timer with LOCKOUT-1.
REQ-022 ALARM:
- ignore enter, prog and relock;
- decrement the timer each cycle;
- when the timer reads 0, go to IDLE with fail_cnt=0;
- total alarm duration is exactly LOCKOUT cycles.
REQ-023 OPEN:
- the open timer is loaded with OPEN_TIME-1 on entry and decrements each cycle;
- at 0, or on relock=1, go to IDLE;
- prog=1 with no relock goes to PROG with slot index 0.
REQ-024 PROG:
- each enter edge with dial<=30 writes dial into code[slot] and increments slot;
- a write to slot 2 returns to OPEN and reloads the open timer;
- an enter edge with dial>30 is ignored;
- relock=1 aborts to IDLE, keeping any slots already written.
REQ-025 Priority within one cycle: reset > relock > enter edge > timer expiry > prog.
REQ-026 Code registers are 5 bits wide and are compared by exact equality; the stored combination is retained in every state except reset.

Reset
REQ-027 When RST=0 at a clock edge:
- state becomes IDLE;
- code[0..2] reload to CODE0/CODE1/CODE2;
- stage=0, fail_cnt=0, unlocked=0, alarm=0, cnt_load=0, cnt_value=0;
- both timers clear and the registered enter clears.
REQ-028 Reset wins over all other inputs, including mid-attempt, in OPEN, PROG or ALARM; a reset applied in PROG discards programmed codes.
REQ-029 If enter is held high through reset release, no edge is seen until enter goes low and then high again.

Verification
REQ-030 Correct entry: edges at dial=5/sel=01, then dial=20/sel=00, then dial=12/sel=01 -> stage goes 1, 2, then unlocked=1 on the cycle after the third edge.
REQ-031 Wrong value in GOT1: dial=5/sel=01 accepted, then dial=19/sel=00 -> stage=0, fail_cnt=1, cnt_load high for exactly 1 cycle with cnt_value=0.
REQ-032 Lockout: three wrong edges -> alarm=1 for exactly 16 cycles, enters during alarm ignored, then fail_cnt=0 and the state is IDLE.
REQ-033 Reprogram: in OPEN with prog=1, edges at dial=7, 30, 0 -> back in OPEN; after relock, the sequence 7/up, 30/down, 0/up unlocks and 5/20/12 fails.
REQ-034 Auto-relock and held enter: unlocked drops after exactly 64 cycles with no input; enter held high for 10 cycles counts as a single entry.
REQ-035 Reset mid-attempt: RST=0 in GOT2 -> next cycle stage=0, fail_cnt=0, unlocked=0; the default code still unlocks.

Source files
------------

// File: rtl/combo_checker.sv
// Combination lock checker: three-number dial entry, lockout
// alarm, timed unlock window and in-place code reprogramming.
module combo_checker #(
  parameter logic [4:0] CODE0     = 5'd5,
  parameter logic [4:0] CODE1     = 5'd20,
  parameter logic [4:0] CODE2     = 5'd12,
  parameter int         MAX_FAILS = 3,
  parameter int         LOCKOUT   = 16,
  parameter int         OPEN_TIME = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] dial,
  input  logic [1:0] sel,
  input  logic       enter,
  input  logic       relock,
  input  logic       prog,
  output logic       unlocked,
  output logic       alarm,
  output logic [1:0] stage,
  output logic [1:0] fail_cnt,
  output logic       cnt_load,
  output logic [4:0] cnt_value
);

  localparam int TMAX = (LOCKOUT > OPEN_TIME) ? LOCKOUT : OPEN_TIME;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [1:0] DOWN = 2'b00;
  localparam logic [1:0] UP   = 2'b01;

  typedef enum logic [2:0] {
    IDLE, GOT1, GOT2, OPEN, PROG, ALARM
  } state_t;

  state_t          state, state_n;
  logic [4:0]      code0, code1, code2;
  logic [4:0]      code0_n, code1_n, code2_n;
  logic [1:0]      stage_n, fail_n;
  logic [TW-1:0]   timer, timer_n;
  logic            enter_q, arm;
  logic            enter_edge;
  logic            dial_ok;
  logic            wrong;
  logic            load_n;
  logic [2:0]      fail_inc;

  // arm stays low after reset until enter has been seen low once
  assign enter_edge = enter & ~enter_q & arm;
  assign dial_ok    = (dial <= 5'd30);
  assign fail_inc   = {1'b0, fail_cnt} + 3'd1;
  assign cnt_value  = '0;

  // Next-state, counter and code-register decode
  always_comb begin
    state_n = state;
    stage_n = stage;
    fail_n  = fail_cnt;
    timer_n = timer;
    code0_n = code0;
    code1_n = code1;
    code2_n = code2;
    load_n  = 1'b0;
    wrong   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enter_edge) begin
          if (dial_ok && dial == code0 && sel == UP) begin
            state_n = GOT1;
            stage_n = 2'd1;
          end else begin
            wrong = 1'b1;
          end
        end
      end
      GOT1: begin
        if (enter_edge) begin
          if (dial_ok && dial == code1 && sel == DOWN) begin
            state_n = GOT2;
            stage_n = 2'd2;
          end else begin
            wrong = 1'b1;
          end
        end
      end
      GOT2: begin
        if (enter_edge) begin
          if (dial_ok && dial == code2 && sel == UP) begin
            state_n = OPEN;
            stage_n = 2'd0;
            fail_n  = 2'd0;
            timer_n = TW'(OPEN_TIME - 1);
          end else begin
            wrong = 1'b1;
          end
        end
      end
      OPEN: begin
        if (relock) begin
          state_n = IDLE;
        end else if (timer == '0) begin
          state_n = IDLE;
        end else begin
          timer_n = timer - 1'b1;
          if (prog) begin
            state_n = PROG;
            stage_n = 2'd0;
          end
        end
      end
      PROG: begin
        if (relock) begin
          state_n = IDLE;
          stage_n = 2'd0;
        end else if (enter_edge && dial_ok) begin
          unique case (stage)
            2'd0: begin
              code0_n = dial;
              stage_n = 2'd1;
            end
            2'd1: begin
              code1_n = dial;
              stage_n = 2'd2;
            end
            default: begin
              code2_n = dial;
              stage_n = 2'd0;
              state_n = OPEN;
              timer_n = TW'(OPEN_TIME - 1);
            end
          endcase
        end
      end
      ALARM: begin
        if (timer == '0) begin
          state_n = IDLE;
          fail_n  = 2'd0;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        stage_n = 2'd0;
      end
    endcase
    if (wrong) begin
      stage_n = 2'd0;
      load_n  = 1'b1;
      if (fail_inc >= 3'(MAX_FAILS)) begin
        state_n = ALARM;
        fail_n  = 2'(MAX_FAILS);
        timer_n = TW'(LOCKOUT - 1);
      end else begin
        state_n = IDLE;
        fail_n  = fail_inc[1:0];
      end
    end
  end

  // State, code, timer and registered-output update
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      code0    <= CODE0;
      code1    <= CODE1;
      code2    <= CODE2;
      stage    <= 2'd0;
      fail_cnt <= 2'd0;
      timer    <= '0;
      enter_q  <= 1'b0;
      arm      <= 1'b0;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
      cnt_load <= 1'b0;
    end else begin
      state    <= state_n;
      code0    <= code0_n;
      code1    <= code1_n;
      code2    <= code2_n;
      stage    <= stage_n;
      fail_cnt <= fail_n;
      timer    <= timer_n;
      enter_q  <= enter;
      arm      <= arm | ~enter;
      unlocked <= (state_n == OPEN);
      alarm    <= (state_n == ALARM);
      cnt_load <= load_n;
    end
  end

endmodule

// File: tb/tb_combo_checker.sv
// Directed bench for combo_checker: entry, lockout, reprogram,
// auto-relock, held enter and reset behaviour.
module tb_combo_checker;

  logic       clk;
  logic       rst_n;
  logic [4:0] dial;
  logic [1:0] sel;
  logic       enter;
  logic       relock;
  logic       prog;
  logic       unlocked;
  logic       alarm;
  logic [1:0] stage;
  logic [1:0] fail_cnt;
  logic       cnt_load;
  logic [4:0] cnt_value;

  int total;
  int passed;

  combo_checker dut (
    .CLK      (clk),
    .RST      (rst_n),
    .dial     (dial),
    .sel      (sel),
    .enter    (enter),
    .relock   (relock),
    .prog     (prog),
    .unlocked (unlocked),
    .alarm    (alarm),
    .stage    (stage),
    .fail_cnt (fail_cnt),
    .cnt_load (cnt_load),
    .cnt_value(cnt_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] d, input logic [1:0] s);
    enter = 1'b0;
    step();
    dial  = d;
    sel   = s;
    enter = 1'b1;
    step();
    enter = 1'b0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enter  = 1'b0;
    relock = 1'b0;
    prog   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_relock();
    relock = 1'b1;
    step();
    relock = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({unlocked, alarm, cnt_load} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000",
               {unlocked, alarm, cnt_load});
    else passed++;
    total++;
    if (stage !== 2'd0 || fail_cnt !== 2'd0)
      $display("FAIL reset_counts got=%0d/%0d exp=0/0",
               stage, fail_cnt);
    else passed++;
    total++;
    if (cnt_value !== 5'd0)
      $display("FAIL reset_cnt_value got=%0d exp=0", cnt_value);
    else passed++;
  endtask

  task automatic test_correct();
    press(5'd5, 2'b01);
    total++;
    if (stage !== 2'd1)
      $display("FAIL correct_stage1 got=%0d exp=1", stage);
    else passed++;
    press(5'd20, 2'b00);
    total++;
    if (stage !== 2'd2)
      $display("FAIL correct_stage2 got=%0d exp=2", stage);
    else passed++;
    press(5'd12, 2'b01);
    total++;
    if (unlocked !== 1'b1 || stage !== 2'd0)
      $display("FAIL correct_open got=%b/%0d exp=1/0",
               unlocked, stage);
    else passed++;
    do_relock();
    step();
    total++;
    if (unlocked !== 1'b0)
      $display("FAIL correct_relock got=%b exp=0", unlocked);
    else passed++;
  endtask

  task automatic test_wrong_got1();
    press(5'd5, 2'b01);
    press(5'd19, 2'b00);
    total++;
    if (stage !== 2'd0 || fail_cnt !== 2'd1)
      $display("FAIL wrong_counts got=%0d/%0d exp=0/1",
               stage, fail_cnt);
    else passed++;
    total++;
    if (cnt_load !== 1'b1 || cnt_value !== 5'd0)
      $display("FAIL wrong_load got=%b/%0d exp=1/0",
               cnt_load, cnt_value);
    else passed++;
    step();
    total++;
    if (cnt_load !== 1'b0)
      $display("FAIL wrong_load_pulse got=%b exp=0", cnt_load);
    else passed++;
  endtask

  task automatic test_lockout();
    int n;
    do_reset();
    press(5'd1, 2'b01);
    press(5'd5, 2'b11);
    total++;
    if (fail_cnt !== 2'd2 || alarm !== 1'b0)
      $display("FAIL lock_pre got=%0d/%b exp=2/0", fail_cnt, alarm);
    else passed++;
    press(5'd31, 2'b01);
    total++;
    if (alarm !== 1'b1 || fail_cnt !== 2'd3)
      $display("FAIL lock_enter got=%b/%0d exp=1/3", alarm, fail_cnt);
    else passed++;
    n = 1;
    dial = 5'd5;
    sel  = 2'b01;
    for (int i = 0; i < 40; i++) begin
      enter = ~enter;
      prog  = 1'b1;
      step();
      if (alarm) n++;
      else break;
    end
    enter = 1'b0;
    prog  = 1'b0;
    total++;
    if (n !== 16)
      $display("FAIL lock_duration got=%0d exp=16", n);
    else passed++;
    total++;
    if (fail_cnt !== 2'd0 || stage !== 2'd0 || unlocked !== 1'b0)
      $display("FAIL lock_exit got=%0d/%0d/%b exp=0/0/0",
               fail_cnt, stage, unlocked);
    else passed++;
    press(5'd5, 2'b01);
    press(5'd20, 2'b00);
    press(5'd12, 2'b01);
    total++;
    if (unlocked !== 1'b1)
      $display("FAIL lock_then_open got=%b exp=1", unlocked);
    else passed++;
  endtask

  task automatic test_reprogram();
    prog = 1'b1;
    step();
    prog = 1'b0;
    total++;
    if (unlocked !== 1'b0 || stage !== 2'd0)
      $display("FAIL prog_enter got=%b/%0d exp=0/0", unlocked, stage);
    else passed++;
    press(5'd7, 2'b01);
    press(5'd30, 2'b00);
    press(5'd31, 2'b01);
    total++;
    if (stage !== 2'd2 || unlocked !== 1'b0)
      $display("FAIL prog_ignore31 got=%0d/%b exp=2/0", stage, unlocked);
    else passed++;
    press(5'd0, 2'b01);
    total++;
    if (unlocked !== 1'b1 || stage !== 2'd0)
      $display("FAIL prog_done got=%b/%0d exp=1/0", unlocked, stage);
    else passed++;
    do_relock();
    press(5'd7, 2'b01);
    press(5'd30, 2'b00);
    press(5'd0, 2'b01);
    total++;
    if (unlocked !== 1'b1)
      $display("FAIL prog_newcode got=%b exp=1", unlocked);
    else passed++;
    do_relock();
    press(5'd5, 2'b01);
    total++;
    if (stage !== 2'd0 || fail_cnt !== 2'd1)
      $display("FAIL prog_oldcode got=%0d/%0d exp=0/1", stage, fail_cnt);
    else passed++;
  endtask

  task automatic test_auto_relock();
    int n;
    do_reset();
    press(5'd5, 2'b01);
    press(5'd20, 2'b00);
    press(5'd12, 2'b01);
    n = 0;
    if (unlocked) n = 1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (unlocked) n++;
      else break;
    end
    total++;
    if (n !== 64)
      $display("FAIL auto_relock got=%0d exp=64", n);
    else passed++;
  endtask

  task automatic test_held_enter();
    enter = 1'b0;
    step();
    dial  = 5'd5;
    sel   = 2'b01;
    enter = 1'b1;
    for (int i = 0; i < 10; i++) step();
    total++;
    if (stage !== 2'd1 || fail_cnt !== 2'd0)
      $display("FAIL held_single got=%0d/%0d exp=1/0", stage, fail_cnt);
    else passed++;
    press(5'd20, 2'b00);
    press(5'd12, 2'b01);
    total++;
    if (unlocked !== 1'b1)
      $display("FAIL held_open got=%b exp=1", unlocked);
    else passed++;
    do_relock();
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(5'd9, 2'b01);
    press(5'd5, 2'b01);
    press(5'd20, 2'b00);
    total++;
    if (stage !== 2'd2 || fail_cnt !== 2'd1)
      $display("FAIL mid_pre got=%0d/%0d exp=2/1", stage, fail_cnt);
    else passed++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if (stage !== 2'd0 || fail_cnt !== 2'd0 || unlocked !== 1'b0)
      $display("FAIL mid_reset got=%0d/%0d/%b exp=0/0/0",
               stage, fail_cnt, unlocked);
    else passed++;
    press(5'd5, 2'b01);
    press(5'd20, 2'b00);
    press(5'd12, 2'b01);
    total++;
    if (unlocked !== 1'b1)
      $display("FAIL mid_default got=%b exp=1", unlocked);
    else passed++;
    prog = 1'b1;
    step();
    prog = 1'b0;
    press(5'd7, 2'b01);
    do_reset();
    press(5'd5, 2'b01);
    press(5'd20, 2'b00);
    press(5'd12, 2'b01);
    total++;
    if (unlocked !== 1'b1)
      $display("FAIL prog_reset_code got=%b exp=1", unlocked);
    else passed++;
  endtask

  task automatic test_reset_held_enter();
    rst_n = 1'b0;
    dial  = 5'd5;
    sel   = 2'b01;
    enter = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    total++;
    if (stage !== 2'd0 || fail_cnt !== 2'd0)
      $display("FAIL held_reset got=%0d/%0d exp=0/0", stage, fail_cnt);
    else passed++;
    enter = 1'b0;
    step();
    enter = 1'b1;
    step();
    total++;
    if (stage !== 2'd1)
      $display("FAIL held_reset_edge got=%0d exp=1", stage);
    else passed++;
    enter = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    dial   = 5'd0;
    sel    = 2'b11;
    enter  = 1'b0;
    relock = 1'b0;
    prog   = 1'b0;
    test_reset();
    test_correct();
    test_wrong_got1();
    test_lockout();
    test_reprogram();
    test_auto_relock();
    test_held_enter();
    test_reset_mid();
    test_reset_held_enter();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
